// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter for the 4x16 display register bank.
// Registered one-hot grant doubles as the write strobe; lock holds the port for up to MAX_HOLD cycles.
module regbank_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic                      w_en,
    output logic [ADDR_W-1:0]         w_addr,
    output logic [DATA_W-1:0]         w_data,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(MAX_HOLD + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [HC_W-1:0]    r_hold;
    logic [N_REQ-1:0]   r_gnt;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [DATA_W-1:0]  r_w_data;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_rr_ptr_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [HC_W-1:0]    w_hold_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [IDX_W:0]     w_pick;
    logic               w_hit;
    logic [IDX_W-1:0]   w_win;
    logic               w_cont;
    logic               w_load;
    logic [IDX_W-1:0]   w_src;

    // (p + k) mod N_REQ for k < N_REQ; works for non-power-of-two N_REQ.
    function automatic logic [IDX_W-1:0] f_add(input logic [IDX_W-1:0] p, input int k);
        logic [IDX_W:0] s;
        s = {1'b0, p} + (IDX_W+1)'(k);
        if (s >= (IDX_W+1)'(N_REQ))
            s = s - (IDX_W+1)'(N_REQ);
        return s[IDX_W-1:0];
    endfunction

    // Returns {hit, index} of the first set request scanning from ptr upward.
    function automatic logic [IDX_W:0] f_pick(input logic [N_REQ-1:0] rq, input logic [IDX_W-1:0] ptr);
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] j;
        hit = 1'b0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = f_add(ptr, i);
            if (rq[j]) begin
                hit = 1'b1;
                idx = j;
            end
        end
        return {hit, idx};
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_hold_nxt   = r_hold;
        w_gnt_nxt    = '0;
        w_load       = 1'b0;
        w_src        = r_owner;

        // On release the old owner drops to last priority.
        w_pick_ptr = (r_state == S_GRANT) ? f_add(r_owner, 1) : r_rr_ptr;
        w_pick     = f_pick(req, w_pick_ptr);
        w_hit      = w_pick[IDX_W];
        w_win      = w_pick[IDX_W-1:0];
        w_cont     = req[r_owner] && lock[r_owner] && (r_hold < HC_W'(MAX_HOLD));

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_win;
                    w_hold_nxt  = HC_W'(1);
                    w_load      = 1'b1;
                    w_src       = w_win;
                end
            end
            S_GRANT: begin
                if (w_cont) begin
                    w_hold_nxt = r_hold + HC_W'(1);
                    w_load     = 1'b1;
                    w_src      = r_owner;
                end else begin
                    w_rr_ptr_nxt = w_pick_ptr;
                    if (w_hit) begin
                        w_owner_nxt = w_win;
                        w_hold_nxt  = HC_W'(1);
                        w_load      = 1'b1;
                        w_src       = w_win;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_hold_nxt  = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_addr_nxt = r_w_addr;
        w_data_nxt = r_w_data;
        if (w_load) begin
            w_gnt_nxt[w_src] = 1'b1;
            w_addr_nxt       = addr[w_src*ADDR_W +: ADDR_W];
            w_data_nxt       = wdata[w_src*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_hold   <= w_hold_nxt;
            r_gnt    <= w_gnt_nxt;
            r_w_addr <= w_addr_nxt;
            r_w_data <= w_data_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign w_en   = |r_gnt;
    assign w_addr = r_w_addr;
    assign w_data = r_w_data;
    assign owner  = r_owner;
    assign busy   = (r_state == S_GRANT);

endmodule
